gtfmac_vnc_lat_seq: RTL

GTFMAC_VNC_LAT_SEQ -- requirements
Module: gtfmac_vnc_lat_seq

---
 rtl/gtfmac_vnc_lat_seq_if.sv | 28 ++
 rtl/gtfmac_vnc_lat_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gtfmac_vnc_lat_seq_if.sv
// Latency-monitor side of the sequencer: collect/pop/clear control out,
// record count and popped timestamp pair back.
interface gtfmac_vnc_lat_seq_if #(
    parameter int TIMER_WIDTH    = 16,
    parameter int RAM_ADDR_WIDTH = 12
);
    logic                      lm_go;
    logic                      lm_pop;
    logic                      lm_clear;
    logic [31:0]               lm_lat_pkt_cnt;
    logic                      lm_full;
    logic [RAM_ADDR_WIDTH:0]   lm_datav;
    logic                      lm_time_rdy;
    logic [TIMER_WIDTH-1:0]    lm_snd_time;
    logic [TIMER_WIDTH-1:0]    lm_rcv_time;

    // Sequencer side
    modport master (
        output lm_go, lm_pop, lm_clear, lm_lat_pkt_cnt,
        input  lm_full, lm_datav, lm_time_rdy, lm_snd_time, lm_rcv_time
    );

    // Latency monitor side
    modport slave (
        input  lm_go, lm_pop, lm_clear, lm_lat_pkt_cnt,
        output lm_full, lm_datav, lm_time_rdy, lm_snd_time, lm_rcv_time
    );
endinterface

// File: rtl/gtfmac_vnc_lat_seq.sv
// Latency-run sequencer: clears the monitor, lets it collect until full or
// timeout, then drains every stored record one pop at a time and keeps
// count/sum/min/max of the rx-tx timestamp deltas.
module gtfmac_vnc_lat_seq #(
    parameter int TIMER_WIDTH    = 16,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int TO_WIDTH       = 24
) (
    input  logic                     axi_clk,
    input  logic                     axi_rstn,
    input  logic                     start,
    input  logic                     abort,
    input  logic [31:0]              pkt_cnt,
    input  logic [TO_WIDTH-1:0]      timeout,
    gtfmac_vnc_lat_seq_if.master     lm,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out,
    output logic [31:0]              rec_cnt,
    output logic [TIMER_WIDTH+31:0]  lat_sum,
    output logic [TIMER_WIDTH-1:0]   lat_min,
    output logic [TIMER_WIDTH-1:0]   lat_max
);

    localparam logic [TO_WIDTH-1:0] TO_ONE = TO_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ARM, S_COLLECT, S_POP, S_WAIT, S_DONE
    } state_t;

    state_t                   state, state_nx;
    logic                     to_set;
    logic [TO_WIDTH-1:0]      to_cnt;
    logic [31:0]              pkt_cnt_q;
    logic                     go_q, pop_q, clear_q, done_q;
    logic [RAM_ADDR_WIDTH:0]  datav;
    logic [TIMER_WIDTH-1:0]   delta;
    logic [TIMER_WIDTH+32:0]  sum_ext;
    logic                     run_start, rec_take;

    assign datav     = lm.lm_datav;
    // Unsigned subtraction wraps modulo 2^TIMER_WIDTH, so a timer rollover
    // between send and receive still yields the true latency.
    assign delta     = lm.lm_rcv_time - lm.lm_snd_time;
    assign sum_ext   = {1'b0, lat_sum} + {33'd0, delta};
    assign run_start = (state == S_IDLE) && (state_nx == S_CLEAR);
    assign rec_take  = (state == S_WAIT) && (state_nx == S_POP);

    assign busy              = (state != S_IDLE);
    assign done              = done_q;
    assign lm.lm_go          = go_q;
    assign lm.lm_pop         = pop_q;
    assign lm.lm_clear       = clear_q;
    assign lm.lm_lat_pkt_cnt = pkt_cnt_q;

    // State register
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) state <= S_IDLE;
        else           state <= state_nx;
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_nx = state;
        to_set   = 1'b0;
        if (state != S_IDLE && abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start && !abort) state_nx = S_CLEAR;
                S_CLEAR:   state_nx = S_ARM;
                S_ARM:     state_nx = (pkt_cnt_q == 32'd0) ? S_DONE : S_COLLECT;
                S_COLLECT: begin
                    // Monitor full takes priority over a coincident timeout
                    if (lm.lm_full) begin
                        state_nx = S_POP;
                    end else if (timeout != '0 && to_cnt == timeout - TO_ONE) begin
                        state_nx = S_POP;
                        to_set   = 1'b1;
                    end
                end
                S_POP:     state_nx = (datav == '0) ? S_DONE : S_WAIT;
                S_WAIT:    if (lm.lm_time_rdy) state_nx = S_POP;
                S_DONE:    state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    // Control strobes registered from the next state so they are glitch-free
    // and drop on the same edge that abort forces IDLE. lm_pop lands in the
    // first WAIT cycle, keeping pops two cycles behind the previous record.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            go_q    <= 1'b0;
            pop_q   <= 1'b0;
            clear_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            go_q    <= (state_nx == S_COLLECT);
            pop_q   <= (state == S_POP) && (state_nx == S_WAIT);
            clear_q <= (state_nx == S_CLEAR);
            done_q  <= (state_nx == S_DONE);
        end
    end

    // COLLECT cycle counter, restarts from 0 on every entry
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn)                to_cnt <= '0;
        else if (state == S_COLLECT)  to_cnt <= to_cnt + TO_ONE;
        else                          to_cnt <= '0;
    end

    // Run parameters and latency statistics
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            pkt_cnt_q <= '0;
            timed_out <= 1'b0;
            rec_cnt   <= '0;
            lat_sum   <= '0;
            lat_min   <= '1;
            lat_max   <= '0;
        end else if (run_start) begin
            pkt_cnt_q <= pkt_cnt;
            timed_out <= 1'b0;
            rec_cnt   <= '0;
            lat_sum   <= '0;
            lat_min   <= '1;
            lat_max   <= '0;
        end else begin
            if (to_set) timed_out <= 1'b1;
            if (rec_take) begin
                if (rec_cnt != '1) rec_cnt <= rec_cnt + 32'd1;
                lat_sum <= sum_ext[TIMER_WIDTH+32] ? '1 : sum_ext[TIMER_WIDTH+31:0];
                if (delta < lat_min) lat_min <= delta;
                if (delta > lat_max) lat_max <= delta;
            end
        end
    end

endmodule
